// File: rtl/madd_commit_buffer.sv
// madd_commit_buffer
// Reorder/commit stage behind the multiply-add saturate stage. Results may
// arrive out of commit order; they are parked in a slot array indexed by the
// low bits of commit_id and released strictly in commit_id order to the
// register-file write port. Entries with commit_flag=0 retire without a write.
//
// Optional build macro: COMMIT_WINDOW_CHECK_EN
//   defined   -> window_error_o flags any accept whose commit_id lies DEPTH or
//                more ahead of head_id (sticky until reset or restart)
//   undefined -> no check logic, window_error_o tied low
module madd_commit_buffer #(
  parameter int  DATA_WIDTH = 16,
  parameter int  N_BLOCKS   = 256,
  parameter int  DEPTH      = 8,
  localparam int BLOCK_W    = $clog2(N_BLOCKS)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    enable_i,
  input  logic                    restart_i,
  // upstream result port
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [BLOCK_W-1:0]      in_block_i,
  input  logic [3:0]              in_dest_i,
  input  logic [2*DATA_WIDTH-1:0] in_result_i,
  input  logic [8:0]              in_commit_id_i,
  input  logic                    in_commit_flag_i,
  // register-file write port
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [BLOCK_W-1:0]      out_block_o,
  output logic [3:0]              out_dest_o,
  output logic [DATA_WIDTH-1:0]   out_data_o,
  output logic [8:0]              out_commit_id_o,
  // status
  output logic [8:0]              head_id_o,
  output logic                    retire_pulse_o,
  output logic                    window_error_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int ID_W  = 9;

  typedef struct packed {
    logic [BLOCK_W-1:0]    block;
    logic [3:0]            dest;
    logic [DATA_WIDTH-1:0] data;
    logic [ID_W-1:0]       id;
    logic                  flag;
  } entry_t;

  // Slot storage: payload array plus a separate valid vector
  entry_t              slot_q [DEPTH];
  logic [DEPTH-1:0]    slot_valid_q, slot_valid_d;

  // Commit pointer
  logic [ID_W-1:0]     head_id_q, head_id_d;

  // Output register
  logic                  out_valid_q, out_valid_d;
  logic [BLOCK_W-1:0]    out_block_q, out_block_d;
  logic [3:0]            out_dest_q, out_dest_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ID_W-1:0]       out_id_q, out_id_d;

  logic                retire_q, retire_d;

  // Handshake / release decode
  logic [IDX_W-1:0]    in_idx;
  logic [IDX_W-1:0]    head_idx;
  entry_t              in_entry;
  entry_t              head_entry;
  logic                accept;
  logic                head_match;
  logic                out_free;
  logic                do_release;

  // Only the low half of the saturated result is written back.
  logic                unused_result_hi;
  assign unused_result_hi = ^in_result_i[2*DATA_WIDTH-1:DATA_WIDTH];

  // Decode slot indices, acceptance and the release condition for this cycle.
  always_comb begin
    in_idx     = in_commit_id_i[IDX_W-1:0];
    head_idx   = head_id_q[IDX_W-1:0];
    head_entry = slot_q[head_idx];

    in_entry.block = in_block_i;
    in_entry.dest  = in_dest_i;
    in_entry.data  = in_result_i[DATA_WIDTH-1:0];
    in_entry.id    = in_commit_id_i;
    in_entry.flag  = in_commit_flag_i;

    in_ready_o = enable_i & ~restart_i & ~slot_valid_q[in_idx];
    accept     = in_valid_i & in_ready_o;

    // An aliased future id sitting in the head slot must not be released.
    head_match = slot_valid_q[head_idx] & (head_entry.id == head_id_q);
    out_free   = ~out_valid_q | out_ready_i;
    do_release = enable_i & ~restart_i & head_match & out_free;
  end

  // Next-state logic for slot valids, head pointer, output register and pulse.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can
    // leave one unassigned and infer a latch.
    slot_valid_d = slot_valid_q;
    head_id_d    = head_id_q;
    out_valid_d  = out_valid_q;
    out_block_d  = out_block_q;
    out_dest_d   = out_dest_q;
    out_data_d   = out_data_q;
    out_id_d     = out_id_q;
    retire_d     = 1'b0;

    if (enable_i) begin
      if (restart_i) begin
        // Program restart discards everything buffered, including the
        // entry currently sitting in the output register.
        slot_valid_d = '0;
        head_id_d    = '0;
        out_valid_d  = 1'b0;
      end else begin
        if (accept) begin
          slot_valid_d[in_idx] = 1'b1;
        end

        if (do_release) begin
          slot_valid_d[head_idx] = 1'b0;
          head_id_d              = head_id_q + 9'd1;
          retire_d               = 1'b1;
        end

        if (do_release && head_entry.flag) begin
          out_valid_d = 1'b1;
          out_block_d = head_entry.block;
          out_dest_d  = head_entry.dest;
          out_data_d  = head_entry.data;
          out_id_d    = head_entry.id;
        end else if (out_ready_i) begin
          // Either nothing released or a silent retire: the consumer has
          // taken whatever was presented, so the port goes idle.
          out_valid_d = 1'b0;
        end
      end
    end
  end

  // Control and output state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    if (reset_i) begin
      slot_valid_q <= '0;
      head_id_q    <= '0;
      out_valid_q  <= 1'b0;
      out_block_q  <= '0;
      out_dest_q   <= '0;
      out_data_q   <= '0;
      out_id_q     <= '0;
      retire_q     <= 1'b0;
    end else begin
      slot_valid_q <= slot_valid_d;
      head_id_q    <= head_id_d;
      out_valid_q  <= out_valid_d;
      out_block_q  <= out_block_d;
      out_dest_q   <= out_dest_d;
      out_data_q   <= out_data_d;
      out_id_q     <= out_id_d;
      retire_q     <= retire_d;
    end
  end

  // Slot payload write on accept.
  always_ff @(posedge clk_i) begin
    // NOTE: payload storage is deliberately not reset; slot_valid_q gates
    // every read, so stale payload is never observed.
    if (accept) begin
      slot_q[in_idx] <= in_entry;
    end
  end

`ifdef COMMIT_WINDOW_CHECK_EN
  logic [ID_W-1:0] window_dist;
  logic            window_error_q, window_error_d;

  // Flag accepts that land outside the reorder window ahead of head_id.
  always_comb begin
    window_dist    = in_commit_id_i - head_id_q;
    window_error_d = window_error_q;
    if (enable_i && restart_i) begin
      window_error_d = 1'b0;
    end else if (accept && (32'(window_dist) >= DEPTH)) begin
      window_error_d = 1'b1;
    end
  end

  // Sticky window error register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      window_error_q <= 1'b0;
    end else begin
      window_error_q <= window_error_d;
    end
  end

  assign window_error_o = window_error_q;
`else
  assign window_error_o = 1'b0;
`endif

  assign out_valid_o     = out_valid_q;
  assign out_block_o     = out_block_q;
  assign out_dest_o      = out_dest_q;
  assign out_data_o      = out_data_q;
  assign out_commit_id_o = out_id_q;
  assign head_id_o       = head_id_q;
  assign retire_pulse_o  = retire_q;

endmodule
